// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: PC, memory read handshake, EXECUTE strobe,
// and debug halt / single-step / PC breakpoint control.
module instruction_fetch #(
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] PC_INC       = ADDR_W'(1)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic [ADDR_W-1:0] ADDR,
  output logic              MEM_RD,
  input  logic              MEM_RDY,
  input  logic [15:0]       MEM_DIN,
  output logic [15:0]       DOUT,
  output logic              EXECUTE,
  input  logic              EXEC_DONE,
  input  logic              PC_LOAD,
  input  logic [ADDR_W-1:0] PC_NEXT,
  output logic [ADDR_W-1:0] PC,
  input  logic              DEBUG_MODE,
  input  logic              DEBUG_STEP,
  input  logic              DEBUG_EN_BKP,
  input  logic [ADDR_W-1:0] BKP_ADDR,
  output logic              HALTED,
  output logic              BKP_HIT
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       dout_q;
  logic              exec_q;
  logic              mem_rd_q;
  logic              halted_q;
  logic              bkp_hit_q;
  logic              step_q;
  logic              skip_q;

  logic [ADDR_W-1:0] npc_d;
  logic              bkp_match_d;

  // Branch target only matters at the retire edge in WAIT
  assign npc_d       = PC_LOAD ? PC_NEXT : pc_q;
  assign bkp_match_d = DEBUG_EN_BKP
                    && (npc_d == BKP_ADDR)
                    && !skip_q;

  assign ADDR    = pc_q;
  assign PC      = pc_q;
  assign MEM_RD  = mem_rd_q;
  assign DOUT    = dout_q;
  assign EXECUTE = exec_q;
  assign HALTED  = halted_q;
  assign BKP_HIT = bkp_hit_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= S_RST;
      pc_q      <= RESET_VECTOR;
      dout_q    <= '0;
      exec_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      halted_q  <= 1'b0;
      bkp_hit_q <= 1'b0;
      step_q    <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      exec_q <= 1'b0;
      unique case (state_q)
        S_RST: begin
          if (DEBUG_MODE) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= S_FETCH;
            mem_rd_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (MEM_RDY) begin
            dout_q   <= MEM_DIN;
            pc_q     <= pc_q + PC_INC;
            mem_rd_q <= 1'b0;
            exec_q   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (EXEC_DONE) begin
            pc_q   <= npc_d;
            skip_q <= 1'b0;
            if (step_q) begin
              step_q   <= 1'b0;
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (DEBUG_MODE) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (bkp_match_d) begin
              state_q   <= S_HALT;
              halted_q  <= 1'b1;
              bkp_hit_q <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
              mem_rd_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (PC_LOAD) pc_q <= PC_NEXT;
          // A breakpoint halt only leaves through an explicit step
          if (DEBUG_STEP) begin
            state_q   <= S_FETCH;
            mem_rd_q  <= 1'b1;
            halted_q  <= 1'b0;
            step_q    <= 1'b1;
            skip_q    <= 1'b1;
            bkp_hit_q <= 1'b0;
          end else if (!DEBUG_MODE && !bkp_hit_q) begin
            state_q  <= S_FETCH;
            mem_rd_q <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_RST;
          mem_rd_q <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
